mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the datapath's instruction and data memory requests (iREN, dREN/dWEN from
//  the request unit) onto one shared variable-latency RAM port. Returns per-requester
//  wait/load so the pipeline stalls until its own access completes. Sits between the
//  request unit / fetch stage and the RAM model.
// PARAMETERS
//  ADDR_W   32  address width (byte address, passed through unmodified)
//  WORD_W   32  data word width
//  TIMEOUT  15  max cycles in a grant state without ramstate==ACCESS before error abort
// PORTS
//  CLK       in   1       system clock, rising edge
//  nRST      in   1       asynchronous active-low reset
//  iREN      in   1       instruction read request (level, held until iwait low)
//  iaddr     in   ADDR_W  instruction address
//  iwait     out  1       1 = instruction not ready; 0 for exactly one cycle on completion
//  iload     out  WORD_W  instruction word, valid when iwait==0
//  dREN      in   1       data read request (level)
//  dWEN      in   1       data write request (level); dREN&dWEN together treated as write
//  daddr     in   ADDR_W  data address
//  dstore    in   WORD_W  store data
//  dwait     out  1       1 = data access not complete; 0 for one cycle on completion
//  dload     out  WORD_W  load data, valid when dwait==0
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  WORD_W  RAM write data
//  ramload   in   WORD_W  RAM read data
//  ramstate  in   2       00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
//  mem_err   out  1       sticky error flag, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, timeout count=0, mem_err=0; ramREN=ramWEN=0, ramaddr=ramstore=0,
//   iwait=dwait=1, iload=dload=0. Reset asserted mid-access aborts immediately.
//  FSM states: IDLE, DGRANT, IGRANT (registered; all outputs decoded from state + inputs).
//  IDLE: RAM enables 0, both waits 1. Next: (dREN|dWEN) -> DGRANT, else iREN -> IGRANT,
//   else IDLE. Data has fixed priority over instruction. Arbitration latency 1 cycle.
//  DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN; iwait=1.
//   ramstate==ACCESS: dwait=0, dload=ramload (combinational, same cycle), next IDLE.
//  IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0; dwait=1.
//   ramstate==ACCESS: iwait=0, iload=ramload same cycle, next IDLE.
//  Grant is non-preemptive: a data request arriving during IGRANT waits for IGRANT to end.
//  Withdrawal: granted requester's enables all 0 before ACCESS -> RAM enables 0 that
//   cycle, no wait pulse, next IDLE.
//  Timeout counter: cleared on entry to any grant state, +1 per grant cycle without ACCESS;
//   saturates. Count reaching TIMEOUT, or ramstate==ERROR in a grant state -> mem_err<=1,
//   next IDLE, no wait pulse (requester stays stalled; mem_err reports the fault).
//  ACCESS seen in IDLE is ignored. dload/iload drive 0 when their wait is 1.
//  Back-to-back: completion cycle -> IDLE -> new grant; min 3 cycles per access with a
//   1-cycle RAM (grant cycle, ACCESS cycle, IDLE cycle).
// TESTING
//  T1 reset: nRST=0 mid-DGRANT -> all outputs at reset values same cycle, state IDLE.
//  T2 iREN=1 iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0x8C220004 -> ramREN=1
//   ramaddr=0x40 for 3 cycles, iwait=0 iload=0x8C220004 in 3rd only, then IDLE.
//  T3 iREN=1 and dREN=1 daddr=0x100 same cycle -> DGRANT first, dload valid, then IGRANT;
//   iwait stays 1 throughout data access.
//  T4 dWEN=1 daddr=0x200 dstore=0xDEADBEEF -> ramWEN=1 ramREN=0 ramstore=0xDEADBEEF,
//   dwait=0 one cycle on ACCESS; dREN=dWEN=1 -> same write behaviour.
//  T5 ramstate held BUSY with TIMEOUT=15 -> mem_err=1 after 15 grant cycles, return IDLE,
//   mem_err stays 1 until nRST.
//  T6 dREN dropped during DGRANT before ACCESS -> ramREN=0 that cycle, no dwait pulse, IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter: data port has fixed priority over instruction fetch.
// Grants are non-preemptive, and a stalled grant aborts to a sticky mem_err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic d_req;
  logic access;
  logic error;
  logic grant_req;

  assign d_req     = dREN | dWEN;
  assign access    = (ramstate == RAM_ACCESS);
  assign error     = (ramstate == RAM_ERROR);
  assign grant_req = (state == DGRANT) ? d_req : iREN;

  // Outputs decode from state plus live inputs, so completion is visible the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (access && d_req) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (access && iREN) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (d_req)     state <= DGRANT;
          else if (iREN) state <= IGRANT;
        end
        DGRANT, IGRANT: begin
          if (error) begin
            mem_err <= 1'b1;
            state   <= IDLE;
          end else if (!grant_req || access) begin
            state <= IDLE;
          end else if (cnt >= CNT_LAST) begin
            // Abort without a wait pulse; the requester stays stalled.
            mem_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; completions are checked by a queue-based monitor
// that is independent of the stimulus sequence.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic is_d, input logic [31:0] load);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_wait_pulse: port=%s load=%h expected=no completion",
               is_d ? "data" : "instr", load);
    end else begin
      e = exp_q.pop_front();
      check(is_d ? "mon_port_is_data" : "mon_port_is_instr", 32'(is_d), 32'(e.is_d));
      check(is_d ? "mon_dload" : "mon_iload", load, e.data);
    end
  endtask

  // Monitor: every wait pulse consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!dwait) pop_check(1'b1, dload);
      if (!iwait) pop_check(1'b0, iload);
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 0);
    check("rst_iwait", 32'(iwait), 1);
    check("rst_dwait", 32'(dwait), 1);
    check("rst_mem_err", 32'(mem_err), 0);
    next_cycle();
    nRST = 1'b1;

    // T2: instruction fetch with two BUSY cycles before ACCESS
    iREN = 1; iaddr = 32'h40; ramstate = FREE;
    push_exp(1'b0, 32'h8C220004);
    @(negedge CLK); check("t2_idle_ramREN", 32'(ramREN), 0);
    next_cycle(); ramstate = BUSY;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("t2_busy_ramREN", 32'(ramREN), 1);
      check("t2_busy_ramaddr", ramaddr, 32'h40);
      check("t2_busy_iwait", 32'(iwait), 1);
      check("t2_busy_iload", iload, 0);
      next_cycle();
    end
    ramstate = ACCESS; ramload = 32'h8C220004;
    @(negedge CLK);
    check("t2_acc_ramREN", 32'(ramREN), 1);
    check("t2_acc_ramaddr", ramaddr, 32'h40);
    next_cycle(); iREN = 0; ramstate = FREE; ramload = 0;
    @(negedge CLK);
    check("t2_after_iwait", 32'(iwait), 1);
    check("t2_after_ramREN", 32'(ramREN), 0);
    next_cycle();

    // T3: simultaneous requests, data served first
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    push_exp(1'b1, 32'h11112222);
    push_exp(1'b0, 32'h33334444);
    @(negedge CLK); next_cycle();
    ramstate = ACCESS; ramload = 32'h11112222;
    @(negedge CLK);
    check("t3_d_ramaddr", ramaddr, 32'h100);
    check("t3_d_iwait", 32'(iwait), 1);
    next_cycle(); dREN = 0; ramstate = FREE;
    @(negedge CLK);
    check("t3_gap_iwait", 32'(iwait), 1);
    next_cycle(); ramstate = ACCESS; ramload = 32'h33334444;
    @(negedge CLK);
    check("t3_i_ramaddr", ramaddr, 32'h44);
    next_cycle(); iREN = 0; ramstate = FREE; ramload = 0;
    @(negedge CLK); next_cycle();

    // T4: plain write, then dREN&dWEN treated as write
    for (int k = 0; k < 2; k++) begin
      dWEN = 1; dREN = (k == 1); daddr = 32'h200 + 32'(k * 4);
      dstore = (k == 0) ? 32'hDEADBEEF : 32'hCAFEF00D;
      push_exp(1'b1, 32'h0);
      @(negedge CLK); next_cycle();
      ramstate = BUSY;
      @(negedge CLK);
      check("t4_ramWEN", 32'(ramWEN), 1);
      check("t4_ramREN", 32'(ramREN), 0);
      check("t4_ramstore", ramstore, dstore);
      check("t4_ramaddr", ramaddr, daddr);
      check("t4_busy_dwait", 32'(dwait), 1);
      next_cycle(); ramstate = ACCESS;
      @(negedge CLK);
      check("t4_acc_ramWEN", 32'(ramWEN), 1);
      next_cycle(); dWEN = 0; dREN = 0; ramstate = FREE;
      @(negedge CLK);
      check("t4_after_dwait", 32'(dwait), 1);
      next_cycle();
    end

    // T6: data read withdrawn before ACCESS; later ACCESS in IDLE is ignored
    dREN = 1; daddr = 32'h300;
    @(negedge CLK); next_cycle();
    ramstate = BUSY;
    @(negedge CLK); check("t6_grant_ramREN", 32'(ramREN), 1);
    next_cycle(); dREN = 0;
    @(negedge CLK);
    check("t6_withdraw_ramREN", 32'(ramREN), 0);
    check("t6_withdraw_dwait", 32'(dwait), 1);
    next_cycle(); ramstate = ACCESS;
    @(negedge CLK);
    check("t6_idle_dwait", 32'(dwait), 1);
    check("t6_idle_iwait", 32'(iwait), 1);
    next_cycle(); ramstate = FREE;

    // T5: RAM stuck BUSY -> abort after 15 grant cycles
    dREN = 1; daddr = 32'h400; ramstate = BUSY;
    @(negedge CLK); next_cycle();
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 1 || k == 15) begin
        check("t5_grant_mem_err", 32'(mem_err), 0);
        check("t5_grant_ramREN", 32'(ramREN), 1);
      end
      next_cycle();
    end
    @(negedge CLK);
    check("t5_abort_mem_err", 32'(mem_err), 1);
    check("t5_abort_ramREN", 32'(ramREN), 0);
    check("t5_abort_dwait", 32'(dwait), 1);
    next_cycle(); dREN = 0;
    next_cycle(); next_cycle();
    @(negedge CLK); check("t5_sticky_mem_err", 32'(mem_err), 1);
    next_cycle();

    // T1: reset asserted mid-DGRANT
    dREN = 1; daddr = 32'h500; ramstate = BUSY;
    @(negedge CLK); next_cycle();
    @(negedge CLK); check("t1_grant_ramaddr", ramaddr, 32'h500);
    next_cycle(); nRST = 0;
    @(negedge CLK);
    check("t1_rst_ramREN", 32'(ramREN), 0);
    check("t1_rst_ramaddr", ramaddr, 0);
    check("t1_rst_dwait", 32'(dwait), 1);
    check("t1_rst_dload", dload, 0);
    check("t1_rst_mem_err", 32'(mem_err), 0);
    next_cycle(); dREN = 0; ramstate = FREE; nRST = 1;
    next_cycle();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
